// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Shares one fixed-latency single-port RAM between the instruction-fetch
//   requester (read only) and the data requester (read/write). One requester
//   is served at a time through IDLE -> ISSUE -> WAIT -> RESP. A tie is broken
//   round-robin, and a request is only sampled while the block is idle.
//
// Parameters
//   AW      address width
//   DW      data width
//   RAM_LAT RAM read latency in cycles (1..3)
//
// Ports
//   clk, rst                        clock; synchronous active-high reset
//   f_req, f_addr                   fetch read request and address
//   f_gnt, f_rvalid, f_rdata        fetch accept pulse, data-valid pulse, held data
//   d_req, d_we, d_addr, d_wdata    data request, write enable, address, write data
//   d_gnt, d_rvalid, d_rdata        data accept pulse, read-valid/write-done pulse,
//                                   held read data
//   ram_en, ram_we, ram_addr,
//   ram_wdata, ram_rdata            RAM access port (rdata valid RAM_LAT after en)
//   busy                            high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          ram_en,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam int CW = $clog2(RAM_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic          r_sel;       // winner of the current transaction: 0 fetch, 1 data
  logic          r_last_gnt;  // round-robin pointer: last port granted
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_f_rdata;
  logic [DW-1:0] r_d_rdata;

  logic          w_any_req;
  logic          w_pick_d;
  logic          w_last_wait;

  assign w_any_req   = f_req | d_req;
  // Data wins when it is the only requester, or on a tie when fetch was
  // granted last.
  assign w_pick_d    = d_req & (~f_req | ~r_last_gnt);
  assign w_last_wait = (r_state == WAIT) && (r_cnt == CW'(1));

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first means every path assigns the output,
  // so no latch is inferred for w_next_state.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:  if (w_any_req)   w_next_state = ISSUE;
      ISSUE:                  w_next_state = WAIT;
      WAIT:  if (w_last_wait) w_next_state = RESP;
      RESP:                   w_next_state = IDLE;
      default:                w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel      <= 1'b0;
      r_last_gnt <= 1'b1;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_f_rdata  <= '0;
      r_d_rdata  <= '0;
    end else begin
      // Request attributes are captured once, on the way into ISSUE; later
      // changes on the request inputs do not affect the RAM access.
      if (r_state == IDLE && w_any_req) begin
        r_sel      <= w_pick_d;
        r_last_gnt <= w_pick_d;
        r_we       <= w_pick_d & d_we;
        r_addr     <= w_pick_d ? d_addr : f_addr;
        if (w_pick_d) r_wdata <= d_wdata;
      end

      if (r_state == ISSUE)     r_cnt <= CW'(RAM_LAT);
      else if (r_state == WAIT) r_cnt <= r_cnt - CW'(1);

      // RAM data is only valid in the final WAIT cycle; writes leave the
      // read-data registers untouched.
      if (w_last_wait && !r_we) begin
        if (r_sel) r_d_rdata <= ram_rdata;
        else       r_f_rdata <= ram_rdata;
      end
    end
  end

  assign f_gnt     = (r_state == ISSUE) & ~r_sel;
  assign d_gnt     = (r_state == ISSUE) &  r_sel;
  assign f_rvalid  = (r_state == RESP)  & ~r_sel;
  assign d_rvalid  = (r_state == RESP)  &  r_sel;
  assign ram_en    = (r_state == ISSUE);
  assign ram_we    = (r_state == ISSUE) &  r_we;
  assign ram_addr  = r_addr;
  assign ram_wdata = r_wdata;
  assign f_rdata   = r_f_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. u_lat1 (RAM_LAT=1) is paired with a small
//   behavioural RAM; u_lat3 (RAM_LAT=3) has its ram_rdata driven directly so
//   the capture cycle can be pinned down with junk data around it.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---- RAM_LAT = 1 instance ----
  logic       f_req = 0, d_req = 0, d_we = 0;
  logic [7:0] f_addr = 0, d_addr = 0, d_wdata = 0;
  logic       f_gnt, f_rvalid, d_gnt, d_rvalid, ram_en, ram_we, busy;
  logic [7:0] f_rdata, d_rdata, ram_addr, ram_wdata, ram_rdata;

  mem_arbiter #(.AW(8), .DW(8), .RAM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  // One-cycle-latency RAM model.
  logic [7:0] mem [256];
  logic [7:0] mem_rd = 8'h00;
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      mem_rd <= mem[ram_addr];
    end
  end
  assign ram_rdata = mem_rd;

  // ---- RAM_LAT = 3 instance ----
  logic       f3_req = 0, d3_req = 0, d3_we = 0;
  logic [7:0] f3_addr = 0, d3_addr = 0, d3_wdata = 0, ram3_rdata = 8'hEE;
  logic       f3_gnt, f3_rvalid, d3_gnt, d3_rvalid, ram3_en, ram3_we, busy3;
  logic [7:0] f3_rdata, d3_rdata, ram3_addr, ram3_wdata;

  mem_arbiter #(.AW(8), .DW(8), .RAM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .f_req(f3_req), .f_addr(f3_addr), .f_gnt(f3_gnt), .f_rvalid(f3_rvalid), .f_rdata(f3_rdata),
    .d_req(d3_req), .d_we(d3_we), .d_addr(d3_addr), .d_wdata(d3_wdata),
    .d_gnt(d3_gnt), .d_rvalid(d3_rvalid), .d_rdata(d3_rdata),
    .ram_en(ram3_en), .ram_we(ram3_we), .ram_addr(ram3_addr), .ram_wdata(ram3_wdata),
    .ram_rdata(ram3_rdata), .busy(busy3)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one cycle; outputs are then sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    mem[8'h11] = 8'h77;

    // ---------------- reset ----------------
    tick(); tick();
    check("rst_busy",    busy,      0);
    check("rst_f_gnt",   f_gnt,     0);
    check("rst_d_gnt",   d_gnt,     0);
    check("rst_ram_en",  ram_en,    0);
    check("rst_ram_we",  ram_we,    0);
    check("rst_f_rdata", f_rdata,   0);
    check("rst_d_rdata", d_rdata,   0);
    check("rst_addr",    ram_addr,  0);
    check("rst_wdata",   ram_wdata, 0);
    rst = 0;

    // ---------------- fetch read, addr changed after grant ----------------
    f_req = 1; f_addr = 8'h10;                     // t0
    tick();                                        // t1 ISSUE
    check("f1_gnt",     f_gnt,    1);
    check("f1_d_gnt",   d_gnt,    0);
    check("f1_ram_en",  ram_en,   1);
    check("f1_ram_we",  ram_we,   0);
    check("f1_addr",    ram_addr, 8'h10);
    check("f1_busy",    busy,     1);
    f_req = 0; f_addr = 8'h11;
    tick();                                        // t2 WAIT
    check("f2_ram_en",  ram_en,   0);
    check("f2_gnt",     f_gnt,    0);
    check("f2_addr",    ram_addr, 8'h10);
    check("f2_rvalid",  f_rvalid, 0);
    tick();                                        // t3 RESP
    check("f3_rvalid",  f_rvalid, 1);
    check("f3_d_rval",  d_rvalid, 0);
    check("f3_rdata",   f_rdata,  8'hA5);
    tick();                                        // t4 IDLE
    check("f4_rvalid",  f_rvalid, 0);
    check("f4_busy",    busy,     0);
    check("f4_hold",    f_rdata,  8'hA5);

    // ---------------- data write then read ----------------
    d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C;
    tick();
    check("w_gnt",      d_gnt,     1);
    check("w_ram_we",   ram_we,    1);
    check("w_addr",     ram_addr,  8'h20);
    check("w_wdata",    ram_wdata, 8'h3C);
    d_req = 0; d_we = 0;
    tick();
    tick();
    check("w_rvalid",   d_rvalid,  1);
    check("w_rdata",    d_rdata,   8'h00);
    tick();
    d_req = 1; d_we = 0; d_addr = 8'h20;
    tick();
    check("r_gnt",      d_gnt,     1);
    check("r_ram_we",   ram_we,    0);
    d_req = 0;
    tick();
    tick();
    check("r_rvalid",   d_rvalid,  1);
    check("r_rdata",    d_rdata,   8'h3C);
    tick();

    // ---------------- continuous tie from reset: alternation ----------------
    rst = 1;
    tick();
    rst = 0;
    f_req = 1; f_addr = 8'h10;
    d_req = 1; d_we = 0; d_addr = 8'h20;           // t0
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("rr%0d_f_gnt", k),  f_gnt,    (k % 8) == 1);
      check($sformatf("rr%0d_d_gnt", k),  d_gnt,    (k % 8) == 5);
      check($sformatf("rr%0d_f_rval", k), f_rvalid, (k % 8) == 3);
      check($sformatf("rr%0d_d_rval", k), d_rvalid, (k % 8) == 7);
    end
    f_req = 0; d_req = 0;
    check("rr_f_rdata", f_rdata, 8'hA5);
    check("rr_d_rdata", d_rdata, 8'h3C);

    // ---------------- reset during WAIT ----------------
    tick();
    f_req = 1; f_addr = 8'h10;
    tick();                                        // ISSUE
    check("rw_gnt", f_gnt, 1);
    f_req = 0;
    tick();                                        // WAIT
    rst = 1;
    tick();
    check("rw_busy",    busy,     0);
    check("rw_rvalid",  f_rvalid, 0);
    check("rw_f_rdata", f_rdata,  0);
    check("rw_d_rdata", d_rdata,  0);
    rst = 0;
    tick();
    check("rw_no_rval", f_rvalid, 0);
    f_req = 1; f_addr = 8'h10; d_req = 1; d_addr = 8'h20;
    tick();
    check("rw_tie_f",   f_gnt, 1);
    check("rw_tie_d",   d_gnt, 0);
    f_req = 0; d_req = 0;
    tick();
    tick();
    check("rw_rvalid2", f_rvalid, 1);
    check("rw_rdata2",  f_rdata,  8'hA5);
    tick();

    // ---------------- RAM_LAT = 3 data read ----------------
    d3_req = 1; d3_we = 0; d3_addr = 8'h40; ram3_rdata = 8'hEE;   // t0
    tick();                                        // t1
    check("l3_gnt",    d3_gnt,    1);
    check("l3_ram_en", ram3_en,   1);
    check("l3_addr",   ram3_addr, 8'h40);
    d3_req = 0;
    tick();                                        // t2
    check("l3_t2_rv",  d3_rvalid, 0);
    check("l3_t2_en",  ram3_en,   0);
    tick();                                        // t3
    check("l3_t3_rv",  d3_rvalid, 0);
    tick();                                        // t4: last WAIT cycle
    check("l3_t4_rv",  d3_rvalid, 0);
    check("l3_t4_bsy", busy3,     1);
    ram3_rdata = 8'h5A;
    tick();                                        // t5 RESP
    ram3_rdata = 8'hEE;
    check("l3_rvalid", d3_rvalid, 1);
    check("l3_rdata",  d3_rdata,  8'h5A);
    check("l3_f_rval", f3_rvalid, 0);
    tick();                                        // t6
    check("l3_t6_rv",  d3_rvalid, 0);
    check("l3_hold",   d3_rdata,  8'h5A);
    check("l3_idle",   busy3,     0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
